// File: rtl/line_fifo_sequencer_if.sv
// Bundle of the solver/parser handshake and external FIFO signals seen by
// line_fifo_sequencer. The sequencer sits on the master side; the
// surrounding parser, solver and FIFO sit on the slave side.
interface line_fifo_sequencer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 1024,
    parameter int COUNT_W    = $clog2(DEPTH + 1)
);
    logic [1:0]            mode;
    logic                  parse_write;
    logic [DATA_WIDTH-1:0] parse_line;
    logic                  solve_write;
    logic [DATA_WIDTH-1:0] solve_line;
    logic                  solve_req;
    logic                  progress;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  fifo_wr_en;
    logic [DATA_WIDTH-1:0] fifo_din;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] option;
    logic                  option_valid;
    logic [COUNT_W-1:0]    occupancy;
    logic                  pass_done;
    logic [7:0]            pass_count;
    logic                  stalled;
    logic                  overflow;

    modport master (
        input  mode, parse_write, parse_line, solve_write, solve_line,
               solve_req, progress, fifo_full, fifo_empty, fifo_dout,
        output fifo_wr_en, fifo_din, fifo_rd_en, option, option_valid,
               occupancy, pass_done, pass_count, stalled, overflow
    );

    modport slave (
        output mode, parse_write, parse_line, solve_write, solve_line,
               solve_req, progress, fifo_full, fifo_empty, fifo_dout,
        input  fifo_wr_en, fifo_din, fifo_rd_en, option, option_valid,
               occupancy, pass_done, pass_count, stalled, overflow
    );
endinterface

// File: rtl/line_fifo_sequencer.sv
// Sequences the shared option-line FIFO between the parser and the solver.
// Muxes the two write sources, gates solver reads, tracks occupancy and
// splits solving into passes over the entries present at the start of each
// pass, flagging a stall when a whole pass assigns no new cell.
module line_fifo_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 1024,
    parameter int COUNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    line_fifo_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                state;
    logic [COUNT_W-1:0]    occupancy_q;
    logic [COUNT_W-1:0]    pass_remaining;
    logic                  progress_seen;
    logic                  option_valid_q;
    logic                  stalled_q;
    logic                  overflow_q;
    logic [7:0]            pass_count_q;
    logic                  sel_write;
    logic [DATA_WIDTH-1:0] sel_line;
    logic                  wr_en;
    logic                  rd_en;
    logic                  pass_end;

    // Pick the write source owning the FIFO in the current top-level mode.
    always_comb begin
        sel_write = 1'b0;
        sel_line  = '0;
        case (bus.mode)
            2'd0: begin
                sel_write = bus.parse_write;
                sel_line  = bus.parse_line;
            end
            2'd1: begin
                sel_write = bus.solve_write;
                sel_line  = bus.solve_line;
            end
            default: begin
                sel_write = 1'b0;
                sel_line  = '0;
            end
        endcase
    end

    assign wr_en    = ~rst & sel_write & ~bus.fifo_full;
    assign rd_en    = ~rst & (state == RUN) & bus.solve_req & ~bus.fifo_empty
                      & (pass_remaining != '0);
    assign pass_end = ~rst & (state == RUN) & (bus.mode == 2'd1)
                      & option_valid_q & (pass_remaining == '0);

    assign bus.fifo_wr_en   = wr_en;
    assign bus.fifo_din     = sel_line;
    assign bus.fifo_rd_en   = rd_en;
    assign bus.option       = bus.fifo_dout;
    assign bus.option_valid = option_valid_q;
    assign bus.occupancy    = occupancy_q;
    assign bus.pass_done    = pass_end;
    assign bus.pass_count   = pass_count_q;
    assign bus.stalled      = stalled_q;
    assign bus.overflow     = overflow_q;

    // Track FIFO occupancy, the read-data valid delay and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            occupancy_q    <= '0;
            option_valid_q <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            option_valid_q <= rd_en;
            overflow_q     <= overflow_q | (sel_write & bus.fifo_full);
            case ({wr_en, rd_en})
                2'b10:   occupancy_q <= occupancy_q + COUNT_W'(1);
                2'b01:   occupancy_q <= occupancy_q - COUNT_W'(1);
                default: occupancy_q <= occupancy_q;
            endcase
        end
    end

    // Pass sequencing FSM: snapshot occupancy, sweep it, then reload or stop.
    always_ff @(posedge clk) begin
        if (rst || bus.mode != 2'd1) begin
            state          <= IDLE;
            pass_remaining <= '0;
            pass_count_q   <= '0;
            stalled_q      <= 1'b0;
            progress_seen  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= LOAD;
                end
                LOAD: begin
                    pass_remaining <= occupancy_q;
                    progress_seen  <= 1'b0;
                    state          <= (occupancy_q == '0) ? DONE : RUN;
                end
                RUN: begin
                    if (rd_en) begin
                        pass_remaining <= pass_remaining - COUNT_W'(1);
                    end
                    progress_seen <= progress_seen | bus.progress;
                    if (pass_end) begin
                        if (pass_count_q != 8'hFF) begin
                            pass_count_q <= pass_count_q + 8'd1;
                        end
                        if (!(progress_seen || bus.progress)) begin
                            stalled_q <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_fifo_sequencer.sv
// Directed bench for line_fifo_sequencer: a small queue-based FIFO stands in
// for the shared option-line FIFO, and every expected value is hand-derived.
module tb_line_fifo_sequencer;

    localparam int DATA_WIDTH = 16;
    localparam int DEPTH      = 1024;
    localparam int COUNT_W    = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst;
    int   check_count;
    int   error_count;

    line_fifo_sequencer_if #(
        .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .COUNT_W(COUNT_W)
    ) bus ();

    line_fifo_sequencer #(
        .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .COUNT_W(COUNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // 100 MHz system clock.
    always #5 clk = ~clk;

    logic [DATA_WIDTH-1:0] fifo_q[$];
    logic [DATA_WIDTH-1:0] fifo_head;
    int                    fifo_level = 0;
    int                    fifo_cap   = DEPTH;

    // Behavioural FIFO: read data appears one cycle after rd_en.
    always @(posedge clk) begin
        if (rst) begin
            fifo_q.delete();
            bus.fifo_dout <= '0;
        end else begin
            if (bus.fifo_rd_en && fifo_q.size() > 0) begin
                fifo_head = fifo_q.pop_front();
                bus.fifo_dout <= fifo_head;
            end
            if (bus.fifo_wr_en) begin
                fifo_q.push_back(bus.fifo_din);
            end
        end
        fifo_level <= fifo_q.size();
    end

    assign bus.fifo_empty = (fifo_level == 0);
    assign bus.fifo_full  = (fifo_level >= fifo_cap);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [1:0] m, input logic pw,
                                  input logic [15:0] pl, input logic sw,
                                  input logic [15:0] sl, input logic req,
                                  input logic prog);
        bus.mode        = m;
        bus.parse_write = pw;
        bus.parse_line  = pl;
        bus.solve_write = sw;
        bus.solve_line  = sl;
        bus.solve_req   = req;
        bus.progress    = prog;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        check_count = 0;
        error_count = 0;
        rst = 1'b1;
        apply_stimulus(2'd0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
        repeat (3) tick();
        rst = 1'b0;
        $display("[TB] reset released");
        check_output("rst_occupancy", 32'(bus.occupancy), 32'd0);
        check_output("rst_state", 32'(dut.state), 32'd0);
        check_output("rst_option_valid", 32'(bus.option_valid), 32'd0);
        check_output("rst_overflow", 32'(bus.overflow), 32'd0);

        // Parser fill with an ignored solver strobe alongside.
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(2'd0, 1'b1, 16'(16'h0011 + i), 1'b1, 16'hBEEF, 1'b0, 1'b0);
            #1;
            check_output("fill_wr_en", 32'(bus.fifo_wr_en), 32'd1);
            check_output("fill_din", 32'(bus.fifo_din), 32'(32'h11 + i));
            tick();
        end
        apply_stimulus(2'd0, 1'b0, 16'h0, 1'b1, 16'hBEEF, 1'b0, 1'b0);
        #1;
        check_output("fill_solve_ignored", 32'(bus.fifo_wr_en), 32'd0);
        tick();
        check_output("fill_occupancy", 32'(bus.occupancy), 32'd5);

        // First pass: 5 reads, 3 write-backs, one progress pulse.
        apply_stimulus(2'd1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
        tick();
        check_output("p1_state_load", 32'(dut.state), 32'd1);
        check_output("p1_no_read_in_load", 32'(bus.fifo_rd_en), 32'd0);
        tick();
        check_output("p1_state_run", 32'(dut.state), 32'd2);
        for (int k = 0; k < 6; k++) begin
            apply_stimulus(2'd1, 1'b0, 16'h0, (k >= 1 && k <= 3), 16'(16'h0020 + k),
                           1'b1, (k == 2));
            #1;
            check_output("p1_rd_en", 32'(bus.fifo_rd_en), 32'(k < 5));
            check_output("p1_option_valid", 32'(bus.option_valid), 32'(k >= 1));
            if (k >= 1) begin
                check_output("p1_option", 32'(bus.option), 32'(32'h10 + k));
            end
            check_output("p1_pass_done", 32'(bus.pass_done), 32'(k == 5));
            tick();
        end
        check_output("p1_pass_count", 32'(bus.pass_count), 32'd1);
        check_output("p1_reload", 32'(dut.state), 32'd1);
        check_output("p1_occupancy", 32'(bus.occupancy), 32'd3);
        apply_stimulus(2'd1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
        tick();
        check_output("p2_load_capture", 32'(dut.pass_remaining), 32'd3);
        check_output("p2_state_run", 32'(dut.state), 32'd2);

        // Second pass: no progress, everything written back -> stall.
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(2'd1, 1'b0, 16'h0, (k >= 1), 16'(16'h0020 + k), 1'b1, 1'b0);
            #1;
            check_output("p2_rd_en", 32'(bus.fifo_rd_en), 32'(k < 3));
            check_output("p2_option_valid", 32'(bus.option_valid), 32'(k >= 1));
            if (k >= 1) begin
                check_output("p2_option", 32'(bus.option), 32'(32'h20 + k));
            end
            check_output("p2_pass_done", 32'(bus.pass_done), 32'(k == 3));
            tick();
        end
        check_output("p2_stalled", 32'(bus.stalled), 32'd1);
        check_output("p2_pass_count", 32'(bus.pass_count), 32'd2);
        check_output("p2_state_done", 32'(dut.state), 32'd3);
        check_output("p2_occupancy", 32'(bus.occupancy), 32'd3);
        apply_stimulus(2'd1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b1);
        for (int k = 0; k < 2; k++) begin
            #1;
            check_output("done_no_read", 32'(bus.fifo_rd_en), 32'd0);
            tick();
        end
        check_output("done_stalled_hold", 32'(bus.stalled), 32'd1);
        check_output("done_count_hold", 32'(bus.pass_count), 32'd2);

        // Abort: leave SOLVE, re-enter, then leave mid-pass with a read in flight.
        apply_stimulus(2'd2, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
        tick();
        check_output("idle_state", 32'(dut.state), 32'd0);
        check_output("idle_count_clear", 32'(bus.pass_count), 32'd0);
        check_output("idle_stalled_clear", 32'(bus.stalled), 32'd0);
        check_output("idle_occupancy", 32'(bus.occupancy), 32'd3);
        apply_stimulus(2'd1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
        tick();
        tick();
        check_output("abort_state_run", 32'(dut.state), 32'd2);
        apply_stimulus(2'd2, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
        #1;
        check_output("abort_last_read", 32'(bus.fifo_rd_en), 32'd1);
        tick();
        check_output("abort_state", 32'(dut.state), 32'd0);
        check_output("abort_inflight_valid", 32'(bus.option_valid), 32'd1);
        check_output("abort_inflight_option", 32'(bus.option), 32'h21);
        check_output("abort_no_pass_done", 32'(bus.pass_done), 32'd0);
        check_output("abort_count", 32'(bus.pass_count), 32'd0);
        check_output("abort_occupancy", 32'(bus.occupancy), 32'd2);

        // Reset in the middle of a pass.
        apply_stimulus(2'd1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
        tick();
        tick();
        #1;
        check_output("mid_run_read", 32'(bus.fifo_rd_en), 32'd1);
        tick();
        check_output("mid_run_state", 32'(dut.state), 32'd2);
        rst = 1'b1;
        repeat (3) tick();
        check_output("rst2_state", 32'(dut.state), 32'd0);
        check_output("rst2_occupancy", 32'(bus.occupancy), 32'd0);
        check_output("rst2_option_valid", 32'(bus.option_valid), 32'd0);
        check_output("rst2_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        check_output("rst2_wr_en", 32'(bus.fifo_wr_en), 32'd0);
        check_output("rst2_pass_done", 32'(bus.pass_done), 32'd0);
        check_output("rst2_pass_count", 32'(bus.pass_count), 32'd0);
        check_output("rst2_stalled", 32'(bus.stalled), 32'd0);
        check_output("rst2_overflow", 32'(bus.overflow), 32'd0);
        check_output("rst2_option", 32'(bus.option), 32'd0);

        // Empty entry into SOLVE: LOAD then DONE without a stall.
        rst = 1'b0;
        tick();
        check_output("empty_state_load", 32'(dut.state), 32'd1);
        tick();
        check_output("empty_state_done", 32'(dut.state), 32'd3);
        check_output("empty_no_read", 32'(bus.fifo_rd_en), 32'd0);
        check_output("empty_not_stalled", 32'(bus.stalled), 32'd0);
        check_output("empty_no_valid", 32'(bus.option_valid), 32'd0);

        // Overflow against a 4-entry FIFO.
        fifo_cap = 4;
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(2'd0, 1'b1, 16'(16'h0031 + i), 1'b0, 16'h0, 1'b0, 1'b0);
            #1;
            check_output("ovf_wr_en", 32'(bus.fifo_wr_en), 32'(i < 4));
            check_output("ovf_flag_before", 32'(bus.overflow), 32'd0);
            tick();
        end
        check_output("ovf_flag", 32'(bus.overflow), 32'd1);
        check_output("ovf_occupancy", 32'(bus.occupancy), 32'd4);
        apply_stimulus(2'd0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
        repeat (2) tick();
        check_output("ovf_sticky", 32'(bus.overflow), 32'd1);
        check_output("ovf_occupancy_hold", 32'(bus.occupancy), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
